// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states, image framing constants.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC,
        ST_HDR,
        ST_LOAD,
        ST_CKSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES     = 4;
    localparam int         WORD_BYTES    = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses for one
// cycle after the byte that completes a word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic        take;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] word_data_q, word_data_d;

    // clear drops any partial word and blocks a byte arriving in the same cycle
    assign take      = byte_valid & ~clear;
    assign word_last = take && (lane_q == 2'(WORD_BYTES - 1));

    always_comb begin
        lane_d       = lane_q;
        shift_d      = shift_q;
        word_valid_d = word_last;
        word_data_d  = word_data_q;
        if (clear) begin
            lane_d = '0;
        end else if (take) begin
            lane_d  = lane_q + 2'd1;
            shift_d = {byte_data, shift_q[23:8]};
            if (word_last) begin
                word_data_d = {byte_data, shift_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (rst) begin
            lane_q       <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
        end else begin
            lane_q       <= lane_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image over a byte stream, writes it into RAM and
// releases the CPU from reset once the payload checksum verifies.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W = 11,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] start_pc,
    output logic              done,
    output logic              error
);

    state_t            state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] start_pc_q, start_pc_d;
    logic [7:0]        cksum_q, cksum_d;
    logic              rx_ready_q, rx_ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;

    logic              byte_ok;
    logic              pk_valid;
    logic              pk_last;
    logic              pk_word_valid;
    logic [31:0]       pk_word_data;
    logic [15:0]       pc_full;
    logic [16:0]       cnt_ext;
    logic [16:0]       last_idx;
    logic              hdr_bad;

    // load_req beats a byte offered in the same cycle
    assign byte_ok  = rx_valid & rx_ready_q & ~load_req;
    assign pk_valid = byte_ok && (state_q == ST_LOAD);

    assign pc_full  = {rx_data, pc_q[7:0]};
    assign cnt_ext  = {1'b0, count_q};
    assign last_idx = cnt_ext - 17'd1;
    assign hdr_bad  = (count_q == 16'd0) || (cnt_ext > (17'd1 << ADDR_W)) ||
                      (pc_full >= count_q);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_req),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word_last  (pk_last),
        .word_valid (pk_word_valid),
        .word_data  (pk_word_data)
    );

    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        count_d    = count_q;
        pc_d       = pc_q;
        word_idx_d = word_idx_q;
        mem_addr_d = mem_addr_q;
        start_pc_d = start_pc_q;
        cksum_d    = cksum_q;
        if (load_req) begin
            state_d    = ST_WAIT_MAGIC;
            hdr_idx_d  = '0;
            word_idx_d = '0;
            cksum_d    = '0;
        end else begin
            case (state_q)
                ST_WAIT_MAGIC: begin
                    if (byte_ok && rx_data == MAGIC) begin
                        state_d   = ST_HDR;
                        hdr_idx_d = '0;
                    end
                end
                ST_HDR: begin
                    if (byte_ok) begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        case (hdr_idx_q)
                            2'd0:    count_d[7:0]  = rx_data;
                            2'd1:    count_d[15:8] = rx_data;
                            2'd2:    pc_d[7:0]     = rx_data;
                            default: pc_d[15:8]    = rx_data;
                        endcase
                        if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                            state_d    = hdr_bad ? ST_ERROR : ST_LOAD;
                            word_idx_d = '0;
                            cksum_d    = '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (byte_ok) begin
                        cksum_d = cksum_q ^ rx_data;
                    end
                    // address is latched with the completing byte so it lines up with word_valid
                    if (pk_last) begin
                        mem_addr_d = word_idx_q;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        if (17'(word_idx_q) == last_idx) begin
                            state_d = ST_CKSUM;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (byte_ok) begin
                        if (rx_data == cksum_q) begin
                            state_d    = ST_RUN;
                            start_pc_d = ADDR_W'(pc_q);
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                default: ;
            endcase
        end
        rx_ready_d  = (state_d == ST_WAIT_MAGIC) || (state_d == ST_HDR) ||
                      (state_d == ST_LOAD) || (state_d == ST_CKSUM);
        done_d      = (state_d == ST_RUN);
        cpu_rst_n_d = (state_d == ST_RUN);
        error_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        pc_q    <= pc_d;
        if (rst) begin
            state_q     <= ST_WAIT_MAGIC;
            hdr_idx_q   <= '0;
            word_idx_q  <= '0;
            mem_addr_q  <= '0;
            start_pc_q  <= '0;
            cksum_q     <= '0;
            rx_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            word_idx_q  <= word_idx_d;
            mem_addr_q  <= mem_addr_d;
            start_pc_q  <= start_pc_d;
            cksum_q     <= cksum_d;
            rx_ready_q  <= rx_ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_wren  = pk_word_valid;
    assign mem_data  = pk_word_data;
    assign mem_addr  = mem_addr_q;
    assign start_pc  = start_pc_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: an image-parsing model predicts RAM writes and the
// final outcome; a monitor checks every write cycle against it.
module tb_program_loader;

    localparam int ADDR_W = 11;
    localparam int M_RUN = 0, M_ERR = 1, M_INC = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst, rx_valid, load_req;
    logic [7:0]        rx_data;
    logic              rx_ready, mem_wren, cpu_rst_n, done, error;
    logic [ADDR_W-1:0] mem_addr, start_pc;
    logic [31:0]       mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t         exp_q[$];
    wr_t         log_q[$];
    wr_t         log_a[$];
    wr_t         mon_e;
    int          exp_status;
    logic [15:0] exp_pc = '0;
    bq_t         img_a, img_bad, img_b, img_lead;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .load_req(load_req), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_rst_n(cpu_rst_n),
        .start_pc(start_pc), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Parses an image from the raw byte list: expected writes, outcome, start pc.
    function automatic void build_model(input bq_t img);
        int i;
        logic [15:0] cnt;
        logic [7:0] ck;
        exp_q.delete();
        i = 0;
        while (i < img.size() && img[i] != 8'hA5) i++;
        if (i + 5 > img.size()) begin exp_status = M_INC; return; end
        cnt    = {img[i+2], img[i+1]};
        exp_pc = {img[i+4], img[i+3]};
        i += 5;
        if (cnt == 0 || int'(cnt) > (1 << ADDR_W) || exp_pc >= cnt) begin
            exp_status = M_ERR;
            return;
        end
        ck = 8'h00;
        for (int k = 0; k < int'(cnt); k++) begin
            if (i + 4 > img.size()) begin exp_status = M_INC; return; end
            ck ^= img[i] ^ img[i+1] ^ img[i+2] ^ img[i+3];
            exp_q.push_back('{a: ADDR_W'(k), d: {img[i+3], img[i+2], img[i+1], img[i]}});
            i += 4;
        end
        if (i >= img.size()) exp_status = M_INC;
        else exp_status = (img[i] == ck) ? M_RUN : M_ERR;
    endfunction

    // Called at a negedge; returns at the negedge after the last transfer.
    task automatic send(input bq_t img, input bit gaps);
        int tries;
        foreach (img[j]) begin
            if (gaps) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = img[j];
            tries = 0;
            while (!rx_ready && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 50) check("rx_ready_timeout", 0, 1);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_final(input string name);
        repeat (2) @(negedge clk);
        check({name, "_done"}, done, exp_status == M_RUN);
        check({name, "_error"}, error, exp_status == M_ERR);
        check({name, "_cpu_rst_n"}, cpu_rst_n, exp_status == M_RUN);
        check({name, "_rx_ready"}, rx_ready, exp_status == M_INC);
        check({name, "_writes_left"}, exp_q.size(), 0);
        if (exp_status == M_RUN) check({name, "_start_pc"}, start_pc, exp_pc);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("reload_error", error, 0);
        check("reload_done", done, 0);
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        check("reload_rx_ready", rx_ready, 1);
    endtask

    task automatic run_image(input string name, input bq_t img, input bit gaps);
        build_model(img);
        log_q.delete();
        send(img, gaps);
        check_final(name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wren) begin
                log_q.push_back('{a: mem_addr, d: mem_data});
                check("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, mon_e.a);
                    check("wr_data", mem_data, mon_e.d);
                end
            end
            check("done_vs_cpu_rst_n", done, cpu_rst_n);
            if (cpu_rst_n) check("start_pc_run", start_pc, exp_pc);
        end
    end

    initial begin
        img_a    = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3,
                     8'h02, 8'h00, 8'h80, 8'hE2, 8'h22};
        img_bad  = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3,
                     8'h02, 8'h00, 8'h80, 8'hE2, 8'hDD};
        img_lead = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
                     8'hA0, 8'hE3, 8'h02, 8'h00, 8'h80, 8'hE2, 8'h22};
        img_b    = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};

        rst = 1'b1; rx_valid = 1'b0; load_req = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_start_pc", start_pc, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", rx_ready, 1);

        // Reference image, back to back
        run_image("img_a", img_a, 1'b0);
        check("img_a_nwrites", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("img_a_w0_addr", log_q[0].a, 0);
            check("img_a_w0_data", log_q[0].d, 32'hE3A00001);
            check("img_a_w1_addr", log_q[1].a, 1);
            check("img_a_w1_data", log_q[1].d, 32'hE2800002);
        end
        check("img_a_done_lit", done, 1);
        check("img_a_start_pc_lit", start_pc, 1);
        log_a = log_q;
        pulse_load();

        // Corrupted checksum
        run_image("img_bad", img_bad, 1'b0);
        check("img_bad_nwrites", log_q.size(), 2);
        check("img_bad_error_lit", error, 1);
        pulse_load();

        // Header rejects
        run_image("cnt0", '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        check("cnt0_nwrites", log_q.size(), 0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        check("err_ignores_rx", error, 1);
        check("err_rx_ready", rx_ready, 0);
        pulse_load();
        run_image("pc_eq_cnt", '{8'hA5, 8'h02, 8'h00, 8'h02, 8'h00}, 1'b0);
        check("pc_eq_cnt_nwrites", log_q.size(), 0);
        pulse_load();
        run_image("cnt_big", '{8'hA5, 8'h01, 8'h08, 8'h00, 8'h00}, 1'b0);
        check("cnt_big_error_lit", error, 1);
        pulse_load();

        // Leading junk ahead of MAGIC
        run_image("lead", img_lead, 1'b0);
        check("lead_same_as_a", log_q == log_a, 1'b1);
        pulse_load();

        // Abort after 6 payload bytes, with a byte offered alongside load_req
        run_image("partial", '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00,
                               8'h01, 8'h00, 8'hA0, 8'hE3, 8'h02, 8'h00}, 1'b0);
        load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h80;
        @(negedge clk);
        load_req = 1'b0; rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        // MAGIC offered with load_req in WAIT_MAGIC must be dropped
        load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk);
        load_req = 1'b0; rx_valid = 1'b0;
        run_image("img_b", img_b, 1'b0);
        check("img_b_nwrites", log_q.size(), 1);
        if (log_q.size() == 1) begin
            check("img_b_addr", log_q[0].a, 0);
            check("img_b_data", log_q[0].d, 32'h12345678);
        end
        check("img_b_start_pc_lit", start_pc, 0);
        pulse_load();

        // Idle cycles between bytes
        run_image("gaps", img_a, 1'b1);
        check("gaps_same_as_a", log_q == log_a, 1'b1);
        pulse_load();

        // Reset in the middle of a load
        run_image("pre_rst", '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56}, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_cpu_rst_n", cpu_rst_n, 0);
        check("midrst_rx_ready", rx_ready, 0);
        check("midrst_mem_wren", mem_wren, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rx_ready_after", rx_ready, 1);
        run_image("post_rst", img_b, 1'b0);
        check("post_rst_nwrites", log_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
